// File: rtl/mac_scheduler.sv
// Serial MAC sequencer: clear, N_IN issue/hold steps, activation latch, done.
// Optional MAC_SCHED_ABORT_EN adds abort_x70 to cancel a run before LATCH.
module mac_scheduler #(
    parameter int N_IN    = 6,
    parameter int MAC_LAT = 3
) (
    input  logic                    clk_x70,
    input  logic                    reset_x70,
    input  logic                    start_x70,
`ifdef MAC_SCHED_ABORT_EN
    input  logic                    abort_x70,
`endif
    output logic                    ready_x70,
    output logic [$clog2(N_IN)-1:0] x_sel_x70,
    output logic                    mac_clr_x70,
    output logic                    mac_en_x70,
    output logic                    act_load_x70,
    output logic                    done_x70,
    output logic [7:0]              run_cnt_x70
);

    localparam int IW = $clog2(N_IN);
    localparam int SW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_IN - 1);
    localparam logic [SW-1:0] STG_LAST =
        (MAC_LAT > 1) ? SW'(MAC_LAT - 2) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ISSUE,
        S_HOLD,
        S_LATCH,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] stg_q, stg_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic [IW-1:0] xsel_q, xsel_d;
    logic          clr_q, clr_d;
    logic          en_q, en_d;
    logic          act_q, act_d;
    logic          done_q, done_d;
    logic          step_end;
    logic          abort;

`ifdef MAC_SCHED_ABORT_EN
    assign abort = abort_x70;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stg_d    = stg_q;
        cnt_d    = cnt_q;
        step_end = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_x70) state_d = S_CLR;
            end
            S_CLR: begin
                idx_d   = '0;
                stg_d   = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                stg_d = '0;
                if (MAC_LAT > 1) state_d = S_HOLD;
                else             step_end = 1'b1;
            end
            S_HOLD: begin
                if (stg_q == STG_LAST) step_end = 1'b1;
                else                   stg_d = stg_q + 1'b1;
            end
            S_LATCH: begin
                state_d = S_DONE;
                cnt_d   = cnt_q + 8'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (step_end) begin
            stg_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                state_d = S_LATCH;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_ISSUE;
            end
        end

        // cancel only before the sums are committed
        if (abort && (state_q == S_CLR || state_q == S_ISSUE ||
                      state_q == S_HOLD)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            stg_d   = '0;
        end

        // outputs follow the next state so they register with it
        ready_d = (state_d == S_IDLE);
        clr_d   = (state_d == S_CLR);
        en_d    = (state_d == S_ISSUE);
        act_d   = (state_d == S_LATCH);
        done_d  = (state_d == S_DONE);
        xsel_d  = (state_d == S_ISSUE || state_d == S_HOLD) ? idx_d : '0;
    end

    always_ff @(posedge clk_x70 or negedge reset_x70) begin
        if (!reset_x70) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stg_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            xsel_q  <= '0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            xsel_q  <= xsel_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            act_q   <= act_d;
            done_q  <= done_d;
        end
    end

    assign ready_x70    = ready_q;
    assign x_sel_x70    = xsel_q;
    assign mac_clr_x70  = clr_q;
    assign mac_en_x70   = en_q;
    assign act_load_x70 = act_q;
    assign done_x70     = done_q;
    assign run_cnt_x70  = cnt_q;

endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler: default config plus N_IN=2/MAC_LAT=1.
// Abort scenario is compiled when MAC_SCHED_ABORT_EN is defined.
module tb_mac_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, sa, ra, ca, ea, la, da;
    logic [2:0] xa;
    logic [7:0] na;
    logic       rst_b, sb, rb, cb, eb, lb, db;
    logic [0:0] xb;
    logic [7:0] nb;
    logic       abort_a, abort_b;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    mac_scheduler u_a (
        .clk_x70     (clk),
        .reset_x70   (rst_a),
        .start_x70   (sa),
`ifdef MAC_SCHED_ABORT_EN
        .abort_x70   (abort_a),
`endif
        .ready_x70   (ra),
        .x_sel_x70   (xa),
        .mac_clr_x70 (ca),
        .mac_en_x70  (ea),
        .act_load_x70(la),
        .done_x70    (da),
        .run_cnt_x70 (na)
    );

    mac_scheduler #(.N_IN(2), .MAC_LAT(1)) u_b (
        .clk_x70     (clk),
        .reset_x70   (rst_b),
        .start_x70   (sb),
`ifdef MAC_SCHED_ABORT_EN
        .abort_x70   (abort_b),
`endif
        .ready_x70   (rb),
        .x_sel_x70   (xb),
        .mac_clr_x70 (cb),
        .mac_en_x70  (eb),
        .act_load_x70(lb),
        .done_x70    (db),
        .run_cnt_x70 (nb)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {ready, clr, en, act, done, x_sel} for default config, cycle c
    function automatic logic [7:0] exp_a(input int c);
        logic [2:0] x;
        logic       en;
        en = (c >= 2 && c <= 17 && ((c - 2) % 3) == 0);
        x  = (c >= 2 && c <= 19) ? 3'((c - 2) / 3) : 3'd0;
        return {c >= 22, c == 1, en, c == 20, c == 21, x};
    endfunction

    function automatic logic [5:0] exp_b(input int c);
        logic [5:0] t [1:6];
        t[1] = 6'b010000;
        t[2] = 6'b001000;
        t[3] = 6'b001001;
        t[4] = 6'b000100;
        t[5] = 6'b000010;
        t[6] = 6'b100000;
        return t[c];
    endfunction

    initial begin
        int dn, d1, d3, rdy;
        logic seen, ok_all;
        logic [7:0] n0;
        sa = 0; sb = 0; abort_a = 0; abort_b = 0;
        rst_a = 0; rst_b = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", ra, 1);
        check("rst_strobes", {ca, ea, la, da}, 0);
        check("rst_xsel", xa, 0);
        check("rst_cnt", na, 0);
        check("rst_b_ready", rb, 1);
        rst_a = 1; rst_b = 1;
        @(negedge clk);

        // single run, cycle-accurate
        sa = 1; @(negedge clk); sa = 0;
        for (int c = 1; c <= 22; c++) begin
            check($sformatf("run1_c%0d", c),
                  {ra, ca, ea, la, da, xa}, exp_a(c));
            if (c == 21) check("run1_cnt", na, 1);
            @(negedge clk);
        end

        // start held: three back-to-back runs
        rst_a = 0; @(negedge clk); rst_a = 1; @(negedge clk);
        sa = 1; @(negedge clk);
        dn = 0; d1 = 0; d3 = 0; rdy = 0;
        for (int c = 1; c <= 66; c++) begin
            if (da) begin
                dn++;
                if (dn == 1) d1 = c;
                d3 = c;
            end
            if (ra && c < 43) rdy++;
            if (c == 66) sa = 0;
            @(negedge clk);
        end
        check("b2b_dones", dn, 3);
        check("b2b_first", d1, 21);
        check("b2b_third", d3, 65);
        check("b2b_idle_gap", rdy, 1);
        repeat (3) @(negedge clk);
        check("b2b_cnt", na, 3);
        check("b2b_idle", ra, 1);

        // start pulse during HOLD is ignored
        sa = 1; @(negedge clk); sa = 0;
        dn = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) sa = 1;
            if (c == 4) sa = 0;
            if (da) dn++;
            @(negedge clk);
        end
        check("hold_start_dones", dn, 1);
        check("hold_start_cnt", na, 4);

        // async reset mid-run
        sa = 1; @(negedge clk); sa = 0;
        repeat (9) @(negedge clk);
        check("mid_busy", ra, 0);
        rst_a = 0;
        #1;
        check("mid_rst_ready", ra, 1);
        check("mid_rst_out", {ca, ea, la, da, xa}, 0);
        check("mid_rst_cnt", na, 0);
        repeat (2) @(negedge clk);
        rst_a = 1;
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            if (da || la) dn++;
            @(negedge clk);
        end
        check("mid_no_done", dn, 0);
        check("mid_cnt", na, 0);

        // N_IN=2, MAC_LAT=1
        sb = 1; @(negedge clk); sb = 0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("b_c%0d", c), {rb, cb, eb, lb, db, xb}, exp_b(c));
            @(negedge clk);
        end
        check("b_cnt1", nb, 1);
        ok_all = 1'b1;
        for (int r = 2; r <= 256; r++) begin
            sb = 1; @(negedge clk); sb = 0;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                if (db) seen = 1'b1;
                @(negedge clk);
            end
            if (!seen) ok_all = 1'b0;
            if (r == 255) check("b_cnt255", nb, 255);
        end
        check("b_all_done", ok_all, 1);
        check("b_wrap", nb, 0);

`ifdef MAC_SCHED_ABORT_EN
        repeat (2) @(negedge clk);
        n0 = na;
        sa = 1; @(negedge clk); sa = 0;
        repeat (6) @(negedge clk);
        abort_a = 1; @(negedge clk); abort_a = 0;
        check("abort_idle", ra, 1);
        dn = 0;
        for (int c = 0; c < 25; c++) begin
            if (da || la) dn++;
            @(negedge clk);
        end
        check("abort_no_act", dn, 0);
        check("abort_cnt", na, n0);
`else
        n0 = 8'd0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mac_scheduler.md
MAC_SCHEDULER -- requirements
Module: mac_scheduler

Interface
REQ-001 The block SHALL have parameter N_IN, default 6, the number of layer inputs fed serially per run (range 2..16).
REQ-002 The block SHALL have parameter MAC_LAT, default 3, the clocks each MAC accumulate step occupies (range 1..8).
REQ-003 The block SHALL have port clk_x70, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_x70, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start_x70, input, 1 bit: run request, sampled only in IDLE.
REQ-006 The block SHALL have port ready_x70, output, 1 bit: high exactly when the state is IDLE.
REQ-007 The block SHALL have port x_sel_x70, output, $clog2(N_IN) bits: input-mux select and weight-column index.
REQ-008 The block SHALL have port mac_clr_x70, output, 1 bit: clears all MAC accumulators.
REQ-009 The block SHALL have port mac_en_x70, output, 1 bit: launches one MAC accumulate step.
REQ-010 The block SHALL have port act_load_x70, output, 1 bit: loads the ReLU output registers from the MAC sums.
REQ-011 The block SHALL have port done_x70, output, 1 bit: one-cycle pulse marking run completion.
REQ-012 The block SHALL have port run_cnt_x70, output, 8 bits: count of completed runs.

Function
REQ-013 The FSM SHALL have the states IDLE, CLR, ISSUE, HOLD, LATCH and DONE, with every output registered.
REQ-014 In IDLE, with start_x70=1 sampled, the FSM SHALL go to CLR; otherwise it SHALL remain in IDLE.
REQ-015 CLR SHALL last 1 cycle with mac_clr_x70=1, set the input index to 0, and go to ISSUE.
REQ-016 ISSUE SHALL last 1 cycle with mac_en_x70=1 and x_sel_x70=index, then go to HOLD (or go directly to index advance when MAC_LAT=1).
REQ-017 HOLD SHALL last MAC_LAT-1 cycles, counted by a stage counter, with x_sel_x70 held stable and mac_en_x70=0.
REQ-018 At the end of each step, if index<N_IN-1 the FSM SHALL increment the index and go to ISSUE; otherwise it SHALL go to LATCH.
REQ-019 LATCH SHALL last 1 cycle with act_load_x70=1 and go to DONE; the ReLU decision is the activation unit's job, not this block's.
REQ-020 DONE SHALL last 1 cycle with done_x70=1, increment run_cnt_x70, and return to IDLE.
REQ-021 The run latency SHALL be fixed: done_x70 is high in cycle 3+N_IN*MAC_LAT after the start-sampling edge (21 for the defaults).
REQ-022 start_x70 SHALL be ignored in every state other than IDLE, with no queuing.
REQ-023 If start_x70 is held high continuously, back-to-back runs SHALL follow, with exactly one IDLE cycle between DONE and the next CLR.
REQ-024 mac_clr_x70, mac_en_x70, act_load_x70 and done_x70 SHALL be mutually exclusive in every cycle.
REQ-025 run_cnt_x70 SHALL wrap from 255 to 0 without a flag.
REQ-026 x_sel_x70 SHALL never exceed N_IN-1, and SHALL read 0 in IDLE, CLR, LATCH and DONE.

Reset
REQ-027 While reset_x70=0, the FSM SHALL be forced to IDLE asynchronously, with index=0, stage=0 and run_cnt_x70=0.
REQ-028 While reset_x70=0, the outputs SHALL be ready_x70=1, x_sel_x70=0 and all strobes=0.
REQ-029 Reset asserted mid-run SHALL discard the run without a done_x70 pulse or an act_load_x70 pulse.
REQ-030 Reset deassertion SHALL take effect on the first rising clock edge after reset_x70 returns high.

Configuration
REQ-031 With macro MAC_SCHED_ABORT_EN defined, the block SHALL add an input abort_x70 (1 bit).
REQ-032 With MAC_SCHED_ABORT_EN defined, abort_x70=1 sampled in CLR, ISSUE or HOLD SHALL send the FSM to IDLE on the next edge, with no act_load_x70, no done_x70 and run_cnt_x70 unchanged.
REQ-033 With MAC_SCHED_ABORT_EN defined, abort_x70 SHALL be ignored in IDLE, LATCH and DONE.
REQ-034 Without MAC_SCHED_ABORT_EN, the abort_x70 port SHALL NOT exist and every run SHALL complete.

Verification
REQ-035 Bench: defaults, a single-cycle start pulse -> mac_clr at cycle 1; mac_en at cycles 2, 5, 8, 11, 14, 17 with x_sel 0..5; act_load at 20; done at 21; run_cnt=1.
REQ-036 Bench: start held high for 3 runs -> 3 done pulses spaced 22 cycles apart; run_cnt=3; ready high for exactly 1 cycle between runs.
REQ-037 Bench: start pulsed during HOLD of a run -> no effect; exactly one done pulse.
REQ-038 Bench: reset_x70 driven low at cycle 10 of a run -> ready_x70=1 immediately with no clock edge; no done pulse; run_cnt=0.
REQ-039 Bench: MAC_LAT=1, N_IN=2 -> mac_en at cycles 2 and 3, done at cycle 5; 256 runs -> run_cnt wraps to 0.
REQ-040 Bench: MAC_SCHED_ABORT_EN defined, abort at cycle 7 -> IDLE at cycle 8; no act_load; run_cnt unchanged.
